// File: rtl/note_sequencer.sv
// Record/playback sequencer: stores the live note stream as {note, ticks} run-length
// entries in a single-port RAM and replays them with the original tick timing.
module note_sequencer #(
  parameter int NOTE_W = 6,
  parameter int DEPTH  = 256,
  parameter int DUR_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     mode_rec,
  input  logic                     mode_pb,
  input  logic                     loop,
  input  logic                     clear,
  input  logic [NOTE_W-1:0]        note_in,
  output logic [NOTE_W-1:0]        pb_note,
  output logic                     pb_valid,
  output logic                     busy,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic [2:0]               state_dbg
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int ENT_W = NOTE_W + DUR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [DUR_W-1:0] RUN_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REC   = 3'd1,
    S_FLUSH = 3'd2,
    S_FETCH = 3'd3,
    S_PLAY  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [DUR_W-1:0]    run_len_q, run_len_d;
  logic [NOTE_W-1:0]   cur_note_q, cur_note_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic [DUR_W-1:0]    remain_q, remain_d;
  logic                pend_q, pend_d;
  logic [NOTE_W-1:0]   pb_note_q, pb_note_d;
  logic                pb_valid_q, busy_q, full_q;

  logic [ENT_W-1:0]    mem [DEPTH];
  logic [ENT_W-1:0]    rd_data_q;
  logic [IDX_W-1:0]    mem_addr;
  logic                mem_we;
  logic                do_write;
  logic                last_entry;

  assign last_entry = ({1'b0, rd_idx_q} == (count_q - 1'b1));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    run_len_d  = run_len_q;
    cur_note_d = cur_note_q;
    rd_idx_d   = rd_idx_q;
    remain_d   = remain_q;
    pend_d     = pend_q;
    pb_note_d  = pb_note_q;
    do_write   = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mode_rec) begin
          state_d    = S_REC;
          count_d    = '0;
          overflow_d = 1'b0;
          run_len_d  = '0;
        end else if (mode_pb && count_q != '0) begin
          state_d  = S_FETCH;
          rd_idx_d = '0;
          pend_d   = 1'b0;
        end else if (clear) begin
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      S_REC: begin
        // The tick is handled before the exit check so a tick coincident with
        // mode_rec falling is still recorded ahead of the flush.
        if (tick) begin
          if (run_len_q == '0) begin
            cur_note_d = note_in;
            run_len_d  = 1;
          end else if (note_in == cur_note_q && run_len_q != RUN_MAX) begin
            run_len_d = run_len_q + 1'b1;
          end else begin
            do_write   = 1'b1;
            cur_note_d = note_in;
            run_len_d  = 1;
          end
        end
        if (!mode_rec) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        do_write  = (run_len_q != '0);
        run_len_d = '0;
        state_d   = S_IDLE;
      end
      S_FETCH: begin
        if (!mode_pb) begin
          state_d = S_IDLE;
        end else begin
          pb_note_d = rd_data_q[ENT_W-1:DUR_W];
          remain_d  = rd_data_q[DUR_W-1:0];
          pend_d    = tick;
          state_d   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (!mode_pb) begin
          state_d = S_IDLE;
        end else if (tick || pend_q) begin
          pend_d = 1'b0;
          if (remain_q > DUR_W'(1)) begin
            remain_d = remain_q - 1'b1;
          end else if (!last_entry) begin
            rd_idx_d = rd_idx_q + 1'b1;
            state_d  = S_FETCH;
          end else if (loop) begin
            rd_idx_d = '0;
            state_d  = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_write) begin
      if (count_q == FULL_CNT) begin
        overflow_d = 1'b1;
      end else begin
        mem_we  = 1'b1;
        count_d = count_q + 1'b1;
      end
    end

    if (state_d == S_IDLE) pb_note_d = '0;
  end

  // Single address port: writes use count, otherwise the next read index is
  // presented so the entry is ready during the FETCH cycle.
  assign mem_addr = mem_we ? count_q[IDX_W-1:0] : rd_idx_d;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= {cur_note_q, run_len_q};
    rd_data_q <= mem[mem_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      run_len_q  <= '0;
      cur_note_q <= '0;
      rd_idx_q   <= '0;
      remain_q   <= '0;
      pend_q     <= 1'b0;
      pb_note_q  <= '0;
      pb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      run_len_q  <= run_len_d;
      cur_note_q <= cur_note_d;
      rd_idx_q   <= rd_idx_d;
      remain_q   <= remain_d;
      pend_q     <= pend_d;
      pb_note_q  <= pb_note_d;
      pb_valid_q <= (state_d == S_FETCH) || (state_d == S_PLAY);
      busy_q     <= (state_d != S_IDLE);
      full_q     <= (count_d == FULL_CNT);
    end
  end

  assign pb_note   = pb_note_q;
  assign pb_valid  = pb_valid_q;
  assign busy      = busy_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign count     = count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer, built small (DEPTH=4, DUR_W=2) so saturation
// and overflow are reachable with short recordings.
module tb_note_sequencer;

  localparam int NOTE_W = 6;
  localparam int DEPTH  = 4;
  localparam int DUR_W  = 2;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, tick, mode_rec, mode_pb, loop, clear;
  logic [NOTE_W-1:0] note_in, pb_note;
  logic              pb_valid, busy, full, overflow;
  logic [CNT_W-1:0]  count;
  logic [2:0]        state_dbg;

  logic [NOTE_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  note_sequencer #(.NOTE_W(NOTE_W), .DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_rec(mode_rec), .mode_pb(mode_pb),
    .loop(loop), .clear(clear), .note_in(note_in), .pb_note(pb_note),
    .pb_valid(pb_valid), .busy(busy), .full(full), .overflow(overflow),
    .count(count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick_pulse();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rec_ticks(input logic [NOTE_W-1:0] n, input int k);
    note_in = n;
    repeat (k) tick_pulse();
  endtask

  task automatic start_rec();
    @(negedge clk);
    mode_rec = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop_rec();
    mode_rec = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_play(input logic [NOTE_W-1:0] first);
    @(negedge clk);
    mode_pb = 1'b1;
    repeat (2) @(negedge clk);
    check("first_note", pb_note, first);
    check("first_valid", pb_valid, 1);
  endtask

  task automatic play_tick(input bit stop);
    logic [NOTE_W-1:0] e;
    @(negedge clk);
    e = exp_q.pop_front();
    check("pb_note_tick", pb_note, e);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    if (stop) begin
      mode_pb = 1'b0;
      check("end_note", pb_note, 0);
      check("end_valid", pb_valid, 0);
      check("end_busy", busy, 0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic record_5_9();
    start_rec();
    rec_ticks(6'd5, 3);
    check("cnt_before_change", count, 0);
    rec_ticks(6'd9, 1);
    check("cnt_on_change", count, 1);
    rec_ticks(6'd9, 1);
    stop_rec();
    check("cnt_after_flush", count, 2);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; mode_rec = 1'b0; mode_pb = 1'b0;
    loop = 1'b0; clear = 1'b0; note_in = '0;
    repeat (2) @(negedge clk);
    check("rst_pb_note", pb_note, 0);
    check("rst_pb_valid", pb_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", count, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;

    // record {5,3},{9,2}, single playback
    record_5_9();
    check("rec_busy", busy, 0);
    check("rec_full", full, 0);
    check("rec_ovf", overflow, 0);
    exp_q = '{6'd5, 6'd5, 6'd5, 6'd9, 6'd9};
    start_play(6'd5);
    for (int i = 0; i < 5; i++) play_tick(i == 4);

    // looped playback, then abandon mid-note
    loop = 1'b1;
    exp_q = '{6'd5, 6'd5, 6'd5, 6'd9, 6'd9, 6'd5, 6'd5, 6'd5, 6'd9, 6'd9, 6'd5, 6'd5};
    start_play(6'd5);
    for (int i = 0; i < 12; i++) play_tick(1'b0);
    check("loop_mid_note", pb_note, 5);
    mode_pb = 1'b0;
    @(negedge clk);
    check("abort_note", pb_note, 0);
    check("abort_valid", pb_valid, 0);
    check("abort_busy", busy, 0);
    loop = 1'b0;

    // duration saturation: 7 held 5 ticks with a 2-bit count
    start_rec();
    rec_ticks(6'd7, 5);
    stop_rec();
    check("sat_count", count, 2);
    exp_q = '{6'd7, 6'd7, 6'd7, 6'd7, 6'd7};
    start_play(6'd7);
    for (int i = 0; i < 5; i++) play_tick(i == 4);

    // overflow: six distinct notes into four entries
    start_rec();
    for (int i = 1; i <= 4; i++) rec_ticks(NOTE_W'(i), 1);
    check("ovf_cnt3", count, 3);
    rec_ticks(6'd5, 1);
    check("ovf_cnt4", count, 4);
    check("ovf_full", full, 1);
    check("ovf_not_yet", overflow, 0);
    rec_ticks(6'd6, 1);
    check("ovf_set", overflow, 1);
    stop_rec();
    check("ovf_final_cnt", count, 4);
    check("ovf_final_full", full, 1);
    check("ovf_final_flag", overflow, 1);
    exp_q = '{6'd1, 6'd2, 6'd3, 6'd4};
    start_play(6'd1);
    for (int i = 0; i < 4; i++) play_tick(i == 3);

    // clear in IDLE
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_count", count, 0);
    check("clr_ovf", overflow, 0);
    check("clr_full", full, 0);

    // both modes high -> REC; playback with empty sequence ignored
    @(negedge clk);
    mode_rec = 1'b1;
    mode_pb  = 1'b1;
    @(negedge clk);
    check("both_state", state_dbg, 1);
    check("both_busy", busy, 1);
    check("both_valid", pb_valid, 0);
    mode_rec = 1'b0;
    mode_pb  = 1'b0;
    repeat (3) @(negedge clk);
    check("empty_count", count, 0);
    mode_pb = 1'b1;
    repeat (3) @(negedge clk);
    check("empty_pb_busy", busy, 0);
    check("empty_pb_valid", pb_valid, 0);
    mode_pb = 1'b0;

    // asynchronous reset mid-playback
    record_5_9();
    exp_q = '{6'd5};
    start_play(6'd5);
    play_tick(1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_note", pb_note, 0);
    check("arst_valid", pb_valid, 0);
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", pb_valid, 0);
    mode_pb = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
